// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: each master has a one-deep request holding stage, one shared
// master port, and data-phase responses routed back to the master that owns the data phase.
module ahblite_master_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int AW       = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [3:0]    HPROT_M0,
  input  logic [31:0]   HWDATA_M0,
  output logic          HREADY_M0,
  output logic          HRESP_M0,
  output logic [31:0]   HRDATA_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [3:0]    HPROT_M1,
  input  logic [31:0]   HWDATA_M1,
  output logic          HREADY_M1,
  output logic          HRESP_M1,
  output logic [31:0]   HRDATA_M1,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [3:0]    HPROT,
  output logic [2:0]    HBURST,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA,
  output logic          HMASTER
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [3:0]    prot;
  } req_t;

  req_t        m_req [2];
  logic        m_active [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  m_hready;
  logic [1:0]  m_hresp;

  // Only HTRANS[1] matters: SEQ is treated as NONSEQ, BUSY as IDLE.
  logic unused_trans_lsb;
  assign unused_trans_lsb = HTRANS_M0[0] ^ HTRANS_M1[0];

  assign m_req[0]    = '{addr: HADDR_M0, write: HWRITE_M0, size: HSIZE_M0, prot: HPROT_M0};
  assign m_req[1]    = '{addr: HADDR_M1, write: HWRITE_M1, size: HSIZE_M1, prot: HPROT_M1};
  assign m_active[0] = HTRANS_M0[1];
  assign m_active[1] = HTRANS_M1[1];
  assign m_wdata[0]  = HWDATA_M0;
  assign m_wdata[1]  = HWDATA_M1;

  logic [1:0] pend_q, pend_d;
  req_t       req_q [2];
  req_t       req_d [2];
  logic       dph_valid_q, dph_valid_d;
  logic       dph_master_q, dph_master_d;
  logic       gnt_hold_q, gnt_hold_d;
  logic       gnt_last_q, gnt_last_d;
  logic       rr_ptr_q, rr_ptr_d;

  logic gnt_valid, gnt_idx, accept;

  // A held grant keeps the address phase frozen while the slave stretches the bus.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (gnt_hold_q) begin
      gnt_valid = 1'b1;
      gnt_idx   = gnt_last_q;
    end else if (pend_q[0] && pend_q[1]) begin
      gnt_valid = 1'b1;
      gnt_idx   = (ARB_MODE != 0) ? rr_ptr_q : 1'b0;
    end else if (pend_q[0]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b0;
    end else if (pend_q[1]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b1;
    end
  end

  assign accept = HREADY && gnt_valid;

  always_comb begin
    HTRANS = TR_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = 3'b000;
    HPROT  = 4'b0000;
    if (gnt_valid) begin
      HTRANS = TR_NONSEQ;
      HADDR  = req_q[gnt_idx].addr;
      HWRITE = req_q[gnt_idx].write;
      HSIZE  = req_q[gnt_idx].size;
      HPROT  = req_q[gnt_idx].prot;
    end
  end

  assign HBURST  = 3'b000;
  assign HMASTER = dph_master_q;
  assign HWDATA  = m_wdata[dph_master_q];

  assign HREADY_M0 = m_hready[0];
  assign HREADY_M1 = m_hready[1];
  assign HRESP_M0  = m_hresp[0];
  assign HRESP_M1  = m_hresp[1];
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic owner, capture, clear;

    assign owner   = dph_valid_q && (dph_master_q == 1'(gi));
    assign capture = m_hready[gi] && m_active[gi];
    assign clear   = accept && (gnt_idx == 1'(gi));

    // A pending master is stalled, so capture and clear never hit the same cycle.
    assign m_hready[gi] = pend_q[gi] ? 1'b0 : (owner ? HREADY : 1'b1);
    assign m_hresp[gi]  = owner ? HRESP : 1'b0;
    assign pend_d[gi]   = capture || (pend_q[gi] && !clear);
    assign req_d[gi]    = capture ? m_req[gi] : req_q[gi];

    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        req_q[gi] <= '0;
      end else begin
        req_q[gi] <= req_d[gi];
      end
    end
  end

  always_comb begin
    dph_valid_d  = dph_valid_q;
    dph_master_d = dph_master_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_hold_d   = (HTRANS == TR_NONSEQ) && !HREADY;
    gnt_last_d   = gnt_idx;
    if (HREADY) begin
      if (gnt_valid) begin
        dph_valid_d  = 1'b1;
        dph_master_d = gnt_idx;
        rr_ptr_d     = ~gnt_idx;
      end else begin
        dph_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q       <= 2'b00;
      dph_valid_q  <= 1'b0;
      dph_master_q <= 1'b0;
      gnt_hold_q   <= 1'b0;
      gnt_last_q   <= 1'b0;
      rr_ptr_q     <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      dph_valid_q  <= dph_valid_d;
      dph_master_q <= dph_master_d;
      gnt_hold_q   <= gnt_hold_d;
      gnt_last_q   <= gnt_last_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Bench for the two-master arbiter: a fixed-priority and a round-robin instance share stimulus;
// directed scenarios first, then randomized traffic against a transfer-level reference model.
module tb_ahblite_master_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
  } xfer_t;

  logic        HCLK, HRESET;
  logic [31:0] ma [2];
  logic [1:0]  mt [2];
  logic        mw [2];
  logic [2:0]  ms [2];
  logic [3:0]  mp [2];
  logic [31:0] md [2];
  logic        hready, hresp;
  logic [31:0] hrdata;

  wire         o_hrdy0 [2];
  wire         o_hrdy1 [2];
  wire         o_hresp0 [2];
  wire         o_hresp1 [2];
  wire [31:0]  o_hrdata0 [2];
  wire [31:0]  o_hrdata1 [2];
  wire [31:0]  o_haddr [2];
  wire [1:0]   o_htrans [2];
  wire         o_hwrite [2];
  wire [2:0]   o_hsize [2];
  wire [3:0]   o_hprot [2];
  wire [2:0]   o_hburst [2];
  wire [31:0]  o_hwdata [2];
  wire         o_hmaster [2];

  int sel = 0;
  int total = 0;
  int bad = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ahblite_master_arbiter #(.ARB_MODE(gi), .AW(32)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .HADDR_M0(ma[0]), .HTRANS_M0(mt[0]), .HWRITE_M0(mw[0]), .HSIZE_M0(ms[0]),
      .HPROT_M0(mp[0]), .HWDATA_M0(md[0]),
      .HREADY_M0(o_hrdy0[gi]), .HRESP_M0(o_hresp0[gi]), .HRDATA_M0(o_hrdata0[gi]),
      .HADDR_M1(ma[1]), .HTRANS_M1(mt[1]), .HWRITE_M1(mw[1]), .HSIZE_M1(ms[1]),
      .HPROT_M1(mp[1]), .HWDATA_M1(md[1]),
      .HREADY_M1(o_hrdy1[gi]), .HRESP_M1(o_hresp1[gi]), .HRDATA_M1(o_hrdata1[gi]),
      .HADDR(o_haddr[gi]), .HTRANS(o_htrans[gi]), .HWRITE(o_hwrite[gi]), .HSIZE(o_hsize[gi]),
      .HPROT(o_hprot[gi]), .HBURST(o_hburst[gi]), .HWDATA(o_hwdata[gi]),
      .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .HMASTER(o_hmaster[gi])
    );
  end

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic hrdy_of(input int m);
    return (m == 0) ? o_hrdy0[sel] : o_hrdy1[sel];
  endfunction

  function automatic logic hresp_of(input int m);
    return (m == 0) ? o_hresp0[sel] : o_hresp1[sel];
  endfunction

  function automatic logic [31:0] hrdata_of(input int m);
    return (m == 0) ? o_hrdata0[sel] : o_hrdata1[sel];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      mt[m] = 2'b00; ma[m] = '0; mw[m] = 1'b0; ms[m] = 3'd0; mp[m] = 4'd0; md[m] = '0;
    end
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
  endtask

  // Leaves the caller at the start of the first post-reset cycle.
  task automatic do_reset();
    @(negedge HCLK);
    idle_inputs();
    HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic rand_run(input int mode, input int ncyc);
    xfer_t       req_x [2];
    xfer_t       cur [2];
    xfer_t       dp_x;
    bit          req_v [2];
    bit          m_hold [2];
    bit          ehr [2];
    logic [31:0] m_wd [2];
    bit          dp_v, dp_o, hold_v, hold_o, rr, gv, go, sl_err, sl_ph;
    int          sl_wait;
    dp_v = 0; dp_o = 0; hold_v = 0; hold_o = 0; rr = 0; gv = 0; go = 0;
    sl_err = 0; sl_ph = 0; sl_wait = 0; dp_x = '0;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 0; m_hold[m] = 0; ehr[m] = 1; m_wd[m] = '0; req_x[m] = '0; cur[m] = '0;
    end
    for (int c = 0; c < ncyc + 24; c++) begin
      @(negedge HCLK);
      for (int m = 0; m < 2; m++) begin
        if (!m_hold[m]) begin
          if (c < ncyc && $urandom_range(0, 2) != 0) begin
            cur[m].addr  = $urandom & 32'hFFFF_FFFC;
            cur[m].wr    = 1'($urandom_range(0, 1));
            cur[m].size  = 3'($urandom_range(0, 2));
            cur[m].prot  = 4'($urandom);
            cur[m].wdata = $urandom;
            mt[m] = {1'b1, 1'($urandom_range(0, 1))};
          end else begin
            mt[m] = 2'b00;
          end
          ma[m] = cur[m].addr; mw[m] = cur[m].wr; ms[m] = cur[m].size; mp[m] = cur[m].prot;
        end
        md[m] = m_wd[m];
      end
      if (dp_v) begin
        if (sl_err) begin hresp = 1'b1; hready = sl_ph; end
        else begin hresp = 1'b0; hready = (sl_wait == 0); end
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
      hrdata = $urandom;
      if (hold_v) begin gv = 1; go = hold_o; end
      else if (req_v[0] && req_v[1]) begin gv = 1; go = (mode != 0) ? rr : 1'b0; end
      else if (req_v[0]) begin gv = 1; go = 0; end
      else if (req_v[1]) begin gv = 1; go = 1; end
      else begin gv = 0; go = 0; end
      for (int m = 0; m < 2; m++)
        ehr[m] = req_v[m] ? 1'b0 : ((dp_v && dp_o == 1'(m)) ? hready : 1'b1);
      #2;
      chk("rnd_htrans", 32'(o_htrans[sel]), gv ? 32'd2 : 32'd0);
      chk("rnd_haddr", o_haddr[sel], gv ? req_x[go].addr : 32'd0);
      chk("rnd_hwrite", 32'(o_hwrite[sel]), gv ? 32'(req_x[go].wr) : 32'd0);
      chk("rnd_hsize", 32'(o_hsize[sel]), gv ? 32'(req_x[go].size) : 32'd0);
      chk("rnd_hprot", 32'(o_hprot[sel]), gv ? 32'(req_x[go].prot) : 32'd0);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rnd_hready_m%0d", m), 32'(hrdy_of(m)), 32'(ehr[m]));
        chk($sformatf("rnd_hresp_m%0d", m), 32'(hresp_of(m)),
            (dp_v && dp_o == 1'(m)) ? 32'(hresp) : 32'd0);
      end
      if (dp_v) chk("rnd_hmaster", 32'(o_hmaster[sel]), 32'(dp_o));
      if (dp_v && dp_x.wr) chk("rnd_hwdata", o_hwdata[sel], dp_x.wdata);
      chk("rnd_hrdata_m1", hrdata_of(1), hrdata);
      @(posedge HCLK);
      if (dp_v && !hready) begin
        if (sl_wait > 0) sl_wait--;
        sl_ph = 1;
      end
      hold_v = gv && !hready;
      hold_o = go;
      if (hready) begin
        if (gv) begin
          dp_v = 1; dp_o = go; dp_x = req_x[go]; req_v[go] = 0; rr = !go;
          sl_wait = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
          sl_err  = ($urandom_range(0, 7) == 0);
          sl_ph   = 0;
        end else begin
          dp_v = 0;
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (mt[m][1]) begin
          if (ehr[m]) begin
            req_v[m] = 1; req_x[m] = cur[m]; m_hold[m] = 0;
            if (cur[m].wr) m_wd[m] = cur[m].wdata;
          end else begin
            m_hold[m] = 1;
          end
        end else begin
          m_hold[m] = 0;
        end
      end
    end
  endtask

  initial begin
    int ai [2];
    int exp_m, own;
    HRESET = 1'b1;
    idle_inputs();

    // Reset state and a single zero-wait M0 write.
    sel = 0;
    do_reset();
    #2;
    chk("rst_htrans", 32'(o_htrans[sel]), 32'd0);
    chk("rst_hready_m0", 32'(hrdy_of(0)), 32'd1);
    chk("rst_hready_m1", 32'(hrdy_of(1)), 32'd1);
    chk("rst_hresp_m0", 32'(hresp_of(0)), 32'd0);
    chk("rst_hmaster", 32'(o_hmaster[sel]), 32'd0);
    chk("rst_hburst", 32'(o_hburst[sel]), 32'd0);
    mt[0] = 2'b10; ma[0] = 32'h2000_0004; mw[0] = 1'b1; ms[0] = 3'd2; mp[0] = 4'h3;
    #1;
    chk("t1_t_hready_m0", 32'(hrdy_of(0)), 32'd1);
    @(negedge HCLK);
    mt[0] = 2'b00; ma[0] = '0; mw[0] = 1'b0; md[0] = 32'hCAFE_0001;
    #2;
    chk("t1_t1_htrans", 32'(o_htrans[sel]), 32'd2);
    chk("t1_t1_haddr", o_haddr[sel], 32'h2000_0004);
    chk("t1_t1_hwrite", 32'(o_hwrite[sel]), 32'd1);
    chk("t1_t1_hsize", 32'(o_hsize[sel]), 32'd2);
    chk("t1_t1_hready_m0", 32'(hrdy_of(0)), 32'd0);
    @(negedge HCLK);
    #2;
    chk("t1_t2_hwdata", o_hwdata[sel], 32'hCAFE_0001);
    chk("t1_t2_hmaster", 32'(o_hmaster[sel]), 32'd0);
    chk("t1_t2_hready_m0", 32'(hrdy_of(0)), 32'd1);
    chk("t1_t2_htrans", 32'(o_htrans[sel]), 32'd0);

    // Simultaneous requests under fixed priority.
    do_reset();
    mt[0] = 2'b10; ma[0] = 32'h1000_0000; mt[1] = 2'b10; ma[1] = 32'h1000_0100;
    @(negedge HCLK);
    mt[0] = 2'b00; mt[1] = 2'b00;
    #2;
    chk("t2_t1_haddr", o_haddr[sel], 32'h1000_0000);
    chk("t2_t1_hready_m1", 32'(hrdy_of(1)), 32'd0);
    @(negedge HCLK);
    #2;
    chk("t2_t2_haddr", o_haddr[sel], 32'h1000_0100);
    chk("t2_t2_htrans", 32'(o_htrans[sel]), 32'd2);
    chk("t2_t2_hready_m0", 32'(hrdy_of(0)), 32'd1);
    chk("t2_t2_hready_m1", 32'(hrdy_of(1)), 32'd0);
    @(negedge HCLK);
    #2;
    chk("t2_t3_hmaster", 32'(o_hmaster[sel]), 32'd1);
    chk("t2_t3_hready_m1", 32'(hrdy_of(1)), 32'd1);

    // Round-robin with both masters streaming reads.
    sel = 1;
    do_reset();
    ai[0] = 0; ai[1] = 0;
    for (int k = -1; k < 10; k++) begin
      if (k >= 0) @(negedge HCLK);
      mt[0] = 2'b10; ma[0] = 32'h0000_1000 + 32'(4 * ai[0]);
      mt[1] = 2'b10; ma[1] = 32'h0000_2000 + 32'(4 * ai[1]);
      hrdata = 32'hD000_0000 + 32'(k + 1);
      #2;
      if (k >= 0) begin
        exp_m = k % 2;
        chk("t3_htrans", 32'(o_htrans[sel]), 32'd2);
        chk("t3_haddr", o_haddr[sel], (exp_m == 1 ? 32'h0000_2000 : 32'h0000_1000) + 32'(4 * (k / 2)));
        if (k >= 1) begin
          own = (k - 1) % 2;
          chk("t3_hmaster", 32'(o_hmaster[sel]), 32'(own));
          chk("t3_owner_ready", 32'(hrdy_of(own)), 32'd1);
          chk("t3_other_ready", 32'(hrdy_of(1 - own)), 32'd0);
          chk("t3_owner_hrdata", hrdata_of(own), hrdata);
        end
      end
      for (int m = 0; m < 2; m++) if (hrdy_of(m)) ai[m]++;
    end

    // Three slave wait states on an M1 read while M0 is pending.
    sel = 0;
    do_reset();
    mt[1] = 2'b10; ma[1] = 32'h3000_0010;
    @(negedge HCLK);
    mt[1] = 2'b00; mt[0] = 2'b10; ma[0] = 32'h3000_0020;
    #2;
    chk("t4_m1_addr", o_haddr[sel], 32'h3000_0010);
    chk("t4_m0_capt", 32'(hrdy_of(0)), 32'd1);
    for (int w = 0; w < 3; w++) begin
      @(negedge HCLK);
      mt[0] = 2'b00; hready = 1'b0;
      #2;
      chk("t4_wait_htrans", 32'(o_htrans[sel]), 32'd2);
      chk("t4_wait_haddr", o_haddr[sel], 32'h3000_0020);
      chk("t4_wait_hready_m1", 32'(hrdy_of(1)), 32'd0);
    end
    @(negedge HCLK);
    hready = 1'b1; hrdata = 32'hBEEF_1234;
    #2;
    chk("t4_rel_haddr", o_haddr[sel], 32'h3000_0020);
    chk("t4_rel_hready_m1", 32'(hrdy_of(1)), 32'd1);
    chk("t4_rel_hrdata_m1", hrdata_of(1), 32'hBEEF_1234);
    chk("t4_rel_hready_m0", 32'(hrdy_of(0)), 32'd0);
    @(negedge HCLK);
    #2;
    chk("t4_m0_hmaster", 32'(o_hmaster[sel]), 32'd0);
    chk("t4_m0_hready", 32'(hrdy_of(0)), 32'd1);

    // Two-cycle ERROR to M0 with an M1 transfer pending.
    do_reset();
    mt[0] = 2'b10; ma[0] = 32'h4001_0000;
    @(negedge HCLK);
    mt[0] = 2'b00; mt[1] = 2'b10; ma[1] = 32'h3000_0040;
    #2;
    chk("t5_m0_addr", o_haddr[sel], 32'h4001_0000);
    @(negedge HCLK);
    mt[1] = 2'b00; hready = 1'b0; hresp = 1'b1;
    #2;
    chk("t5_e1_hresp_m0", 32'(hresp_of(0)), 32'd1);
    chk("t5_e1_hready_m0", 32'(hrdy_of(0)), 32'd0);
    chk("t5_e1_hresp_m1", 32'(hresp_of(1)), 32'd0);
    chk("t5_e1_haddr", o_haddr[sel], 32'h3000_0040);
    @(negedge HCLK);
    hready = 1'b1;
    #2;
    chk("t5_e2_hresp_m0", 32'(hresp_of(0)), 32'd1);
    chk("t5_e2_hready_m0", 32'(hrdy_of(0)), 32'd1);
    @(negedge HCLK);
    hresp = 1'b0;
    #2;
    chk("t5_m1_hmaster", 32'(o_hmaster[sel]), 32'd1);
    chk("t5_m1_hready", 32'(hrdy_of(1)), 32'd1);
    chk("t5_m1_hresp", 32'(hresp_of(1)), 32'd0);

    // Reset during a waited M1 data phase with M0 pending.
    do_reset();
    mt[1] = 2'b10; ma[1] = 32'h3000_0080;
    @(negedge HCLK);
    mt[1] = 2'b00; mt[0] = 2'b10; ma[0] = 32'h3000_0090;
    @(negedge HCLK);
    mt[0] = 2'b00; hready = 1'b0; HRESET = 1'b1;
    #2;
    chk("t6_wait_hready_m1", 32'(hrdy_of(1)), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0; hready = 1'b1;
    #2;
    chk("t6_htrans", 32'(o_htrans[sel]), 32'd0);
    chk("t6_hready_m0", 32'(hrdy_of(0)), 32'd1);
    chk("t6_hready_m1", 32'(hrdy_of(1)), 32'd1);
    chk("t6_hresp_m1", 32'(hresp_of(1)), 32'd0);
    chk("t6_hmaster", 32'(o_hmaster[sel]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      #2;
      chk("t6_no_stale", 32'(o_htrans[sel]), 32'd0);
    end

    // Randomized traffic in both arbitration modes.
    for (int md_i = 0; md_i < 2; md_i++) begin
      sel = md_i;
      do_reset();
      rand_run(md_i, 400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
